// File: rtl/kb_event_decoder.sv
// kb_event_decoder
//   Turns a stream of PS/2 set-2 scancode bytes into key events for a
//   character ROM. Tracks break (F0) and extended (E0) prefixes, the two
//   shift keys, caps-lock and a two-language layout toggle. Each make code
//   that is not a modifier produces a one-cycle addr_tick together with a
//   new ROM address, followed one cycle later by char_tick.
//   A partially received prefix sequence is abandoned after TIMEOUT_CYCLES
//   idle cycles.
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   rx_done_tick in   strobe: rx_data holds a new byte
//   rx_data      in   [7:0] received byte
//   rom_addr     out  [9:0] {lang, upper, scancode}
//   addr_tick    out  pulse when rom_addr takes a new key value
//   char_tick    out  addr_tick delayed by one cycle
//   caps_on      out  caps-lock state
//   lang         out  layout select (0 English, 1 Thai)
module kb_event_decoder #(
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_data,
  output logic [9:0] rom_addr,
  output logic       addr_tick,
  output logic       char_tick,
  output logic       caps_on,
  output logic       lang
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] K_BRK  = 8'hF0;
  localparam logic [7:0] K_EXT  = 8'hE0;
  localparam logic [7:0] K_SHL  = 8'h12;
  localparam logic [7:0] K_SHR  = 8'h59;
  localparam logic [7:0] K_CAPS = 8'h58;
  localparam logic [7:0] K_LANG = 8'h0E;
  localparam logic [7:0] K_BAT  = 8'hAA;
  localparam logic [7:0] K_ACK  = 8'hFA;
  localparam logic [7:0] K_RSD  = 8'hFE;
  localparam logic [7:0] K_ECHO = 8'hEE;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BRK     = 2'd1,
    S_EXT     = 2'd2,
    S_EXT_BRK = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;

  logic            r_shift_l;
  logic            r_shift_r;
  logic            r_caps;
  logic            r_lang;
  logic [9:0]      r_rom_addr;
  logic            r_addr_tick;
  logic            r_char_tick;

  logic            w_emit;
  logic            w_set_l;
  logic            w_set_r;
  logic            w_clr_l;
  logic            w_clr_r;
  logic            w_tog_caps;
  logic            w_tog_lang;

  // State and timeout counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state and counter: a byte always wins over a coinciding timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (rx_done_tick) begin
      w_cnt_nxt = '0;
      case (r_state)
        S_IDLE: begin
          if (rx_data == K_BRK) begin
            w_state_nxt = S_BRK;
          end else if (rx_data == K_EXT) begin
            w_state_nxt = S_EXT;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        S_BRK: begin
          w_state_nxt = (rx_data == K_BRK) ? S_BRK : S_IDLE;
        end
        S_EXT: begin
          if (rx_data == K_EXT) begin
            w_state_nxt = S_EXT;
          end else if (rx_data == K_BRK) begin
            w_state_nxt = S_EXT_BRK;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        S_EXT_BRK: w_state_nxt = S_IDLE;
        default:   w_state_nxt = S_IDLE;
      endcase
    end else if (r_state != S_IDLE) begin
      if (r_cnt == CNT_MAX) begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end else begin
        w_cnt_nxt = r_cnt + CW'(1);
      end
    end else begin
      w_cnt_nxt = '0;
    end
  end

  // Per-byte actions: modifier updates and event generation.
  always_comb begin
    w_emit     = 1'b0;
    w_set_l    = 1'b0;
    w_set_r    = 1'b0;
    w_clr_l    = 1'b0;
    w_clr_r    = 1'b0;
    w_tog_caps = 1'b0;
    w_tog_lang = 1'b0;
    if (rx_done_tick) begin
      case (r_state)
        S_IDLE: begin
          case (rx_data)
            K_SHL:  w_set_l    = 1'b1;
            K_SHR:  w_set_r    = 1'b1;
            K_CAPS: w_tog_caps = 1'b1;
            K_LANG: w_tog_lang = 1'b1;
            K_BRK, K_EXT, K_BAT, K_ACK, K_RSD, K_ECHO: w_emit = 1'b0;
            default: w_emit = 1'b1;
          endcase
        end
        S_BRK: begin
          // Only the shift releases matter; other break codes are silent.
          if (rx_data == K_SHL) begin
            w_clr_l = 1'b1;
          end else if (rx_data == K_SHR) begin
            w_clr_r = 1'b1;
          end else begin
            w_clr_l = 1'b0;
          end
        end
        default: w_emit = 1'b0;
      endcase
    end else begin
      w_emit = 1'b0;
    end
  end

  // Modifier state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift_l <= 1'b0;
      r_shift_r <= 1'b0;
      r_caps    <= 1'b0;
      r_lang    <= 1'b0;
    end else begin
      if (w_set_l) r_shift_l <= 1'b1;
      else if (w_clr_l) r_shift_l <= 1'b0;
      if (w_set_r) r_shift_r <= 1'b1;
      else if (w_clr_r) r_shift_r <= 1'b0;
      if (w_tog_caps) r_caps <= ~r_caps;
      if (w_tog_lang) r_lang <= ~r_lang;
    end
  end

  // Event outputs; the address uses modifier state from before this byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rom_addr  <= 10'h000;
      r_addr_tick <= 1'b0;
      r_char_tick <= 1'b0;
    end else begin
      r_addr_tick <= w_emit;
      r_char_tick <= r_addr_tick;
      if (w_emit) begin
        r_rom_addr <= {r_lang, (r_shift_l | r_shift_r) ^ r_caps, rx_data};
      end
    end
  end

  assign rom_addr  = r_rom_addr;
  assign addr_tick = r_addr_tick;
  assign char_tick = r_char_tick;
  assign caps_on   = r_caps;
  assign lang      = r_lang;

endmodule

// File: tb/tb_kb_event_decoder.sv
module tb_kb_event_decoder;

  localparam int T = 16;

  logic       clk;
  logic       reset;
  logic       rx_done_tick;
  logic [7:0] rx_data;
  logic [9:0] rom_addr;
  logic       addr_tick;
  logic       char_tick;
  logic       caps_on;
  logic       lang;

  kb_event_decoder #(.TIMEOUT_CYCLES(T)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_done_tick (rx_done_tick),
    .rx_data      (rx_data),
    .rom_addr     (rom_addr),
    .addr_tick    (addr_tick),
    .char_tick    (char_tick),
    .caps_on      (caps_on),
    .lang         (lang)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: prefix flags plus the time of the last byte; a prefix
  // is still alive if the next byte arrives within T cycles of the last one.
  logic       m_shl, m_shr, m_caps, m_lang, m_at, m_ct, m_e0, m_f0;
  logic [9:0] m_addr;
  int         m_cyc, m_last;

  task automatic model_reset();
    m_shl = 0; m_shr = 0; m_caps = 0; m_lang = 0;
    m_at = 0; m_ct = 0; m_addr = 10'h000; m_e0 = 0; m_f0 = 0;
  endtask

  task automatic model_edge(input logic t, input logic [7:0] d, input logic r);
    m_cyc++;
    m_ct = m_at;
    if (r) begin
      model_reset();
    end else begin
      m_at = 0;
      if (t) begin
        if (m_cyc - m_last > T) begin
          m_e0 = 0; m_f0 = 0;
        end
        m_last = m_cyc;
        if (m_f0 && !m_e0) begin
          if (d != 8'hF0) begin
            if (d == 8'h12) m_shl = 0;
            if (d == 8'h59) m_shr = 0;
            m_f0 = 0;
          end
        end else if (m_e0 && !m_f0) begin
          if (d == 8'hF0) m_f0 = 1;
          else if (d != 8'hE0) m_e0 = 0;
        end else if (m_e0 && m_f0) begin
          m_e0 = 0; m_f0 = 0;
        end else begin
          if (d == 8'hF0) m_f0 = 1;
          else if (d == 8'hE0) m_e0 = 1;
          else if (d == 8'h12) m_shl = 1;
          else if (d == 8'h59) m_shr = 1;
          else if (d == 8'h58) m_caps = !m_caps;
          else if (d == 8'h0E) m_lang = !m_lang;
          else if (!(d inside {8'hAA, 8'hFA, 8'hFE, 8'hEE})) begin
            m_at = 1;
            m_addr = {m_lang, (m_shl | m_shr) ^ m_caps, d};
          end
        end
      end
    end
  endtask

  task automatic step(input logic t, input logic [7:0] d, input logic r);
    reset = r; rx_done_tick = t; rx_data = d;
    @(posedge clk);
    model_edge(t, d, r);
    #1;
    reset = 1'b0; rx_done_tick = 1'b0; rx_data = 8'h00;
  endtask

  task automatic chk(input string nm, input logic [9:0] act, input logic [9:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic at, input logic ct,
                         input logic [9:0] ad, input logic cp, input logic lg);
    chk({tag, " addr_tick"}, {9'd0, addr_tick}, {9'd0, at});
    chk({tag, " char_tick"}, {9'd0, char_tick}, {9'd0, ct});
    chk({tag, " rom_addr"},  rom_addr,          ad);
    chk({tag, " caps_on"},   {9'd0, caps_on},   {9'd0, cp});
    chk({tag, " lang"},      {9'd0, lang},      {9'd0, lg});
  endtask

  typedef struct {
    logic       tick;
    logic [7:0] data;
    logic       e_at;
    logic       e_ct;
    logic [9:0] e_addr;
    logic       e_caps;
    logic       e_lang;
  } vec_t;

  vec_t tbl[35];
  logic [7:0] pool[12];

  initial begin
    tbl[0]  = '{1'b1, 8'h1C, 1'b1, 1'b0, 10'h01C, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 10'h01C, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 10'h01C, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 8'h12, 1'b0, 1'b0, 10'h01C, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 8'h1C, 1'b1, 1'b0, 10'h11C, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 8'hF0, 1'b0, 1'b1, 10'h11C, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 8'h12, 1'b0, 1'b0, 10'h11C, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 8'h1C, 1'b1, 1'b0, 10'h01C, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 8'h58, 1'b0, 1'b1, 10'h01C, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 8'h1C, 1'b1, 1'b0, 10'h11C, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 8'h12, 1'b0, 1'b1, 10'h11C, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 8'h1C, 1'b1, 1'b0, 10'h01C, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 8'hF0, 1'b0, 1'b1, 10'h01C, 1'b1, 1'b0};
    tbl[13] = '{1'b1, 8'h12, 1'b0, 1'b0, 10'h01C, 1'b1, 1'b0};
    tbl[14] = '{1'b1, 8'h58, 1'b0, 1'b0, 10'h01C, 1'b0, 1'b0};
    tbl[15] = '{1'b1, 8'h0E, 1'b0, 1'b0, 10'h01C, 1'b0, 1'b1};
    tbl[16] = '{1'b1, 8'h1C, 1'b1, 1'b0, 10'h21C, 1'b0, 1'b1};
    tbl[17] = '{1'b1, 8'h0E, 1'b0, 1'b1, 10'h21C, 1'b0, 1'b0};
    tbl[18] = '{1'b1, 8'h1C, 1'b1, 1'b0, 10'h01C, 1'b0, 1'b0};
    tbl[19] = '{1'b1, 8'h1D, 1'b1, 1'b1, 10'h01D, 1'b0, 1'b0};
    tbl[20] = '{1'b1, 8'hAA, 1'b0, 1'b1, 10'h01D, 1'b0, 1'b0};
    tbl[21] = '{1'b1, 8'hE0, 1'b0, 1'b0, 10'h01D, 1'b0, 1'b0};
    tbl[22] = '{1'b1, 8'h1C, 1'b0, 1'b0, 10'h01D, 1'b0, 1'b0};
    tbl[23] = '{1'b1, 8'h12, 1'b0, 1'b0, 10'h01D, 1'b0, 1'b0};
    tbl[24] = '{1'b1, 8'hE0, 1'b0, 1'b0, 10'h01D, 1'b0, 1'b0};
    tbl[25] = '{1'b1, 8'hF0, 1'b0, 1'b0, 10'h01D, 1'b0, 1'b0};
    tbl[26] = '{1'b1, 8'h12, 1'b0, 1'b0, 10'h01D, 1'b0, 1'b0};
    tbl[27] = '{1'b1, 8'h1C, 1'b1, 1'b0, 10'h11C, 1'b0, 1'b0};
    tbl[28] = '{1'b1, 8'hF0, 1'b0, 1'b1, 10'h11C, 1'b0, 1'b0};
    tbl[29] = '{1'b1, 8'h12, 1'b0, 1'b0, 10'h11C, 1'b0, 1'b0};
    tbl[30] = '{1'b1, 8'h59, 1'b0, 1'b0, 10'h11C, 1'b0, 1'b0};
    tbl[31] = '{1'b1, 8'h3A, 1'b1, 1'b0, 10'h13A, 1'b0, 1'b0};
    tbl[32] = '{1'b1, 8'hF0, 1'b0, 1'b1, 10'h13A, 1'b0, 1'b0};
    tbl[33] = '{1'b1, 8'h59, 1'b0, 1'b0, 10'h13A, 1'b0, 1'b0};
    tbl[34] = '{1'b0, 8'h00, 1'b0, 1'b0, 10'h13A, 1'b0, 1'b0};

    pool = '{8'h12, 8'h59, 8'h58, 8'h0E, 8'hF0, 8'hE0,
             8'hAA, 8'hFA, 8'h1C, 8'h1C, 8'h75, 8'h3A};

    m_cyc = 0; m_last = 0;
    model_reset();
    reset = 1'b1; rx_done_tick = 1'b0; rx_data = 8'h00;

    // Reset state, with a byte presented during reset that must be dropped.
    step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h1C, 1'b1);
    chk_all("reset", 1'b0, 1'b0, 10'h000, 1'b0, 1'b0);

    // Directed table.
    for (int i = 0; i < 35; i++) begin
      step(tbl[i].tick, tbl[i].data, 1'b0);
      chk_all($sformatf("tbl%0d", i), tbl[i].e_at, tbl[i].e_ct,
              tbl[i].e_addr, tbl[i].e_caps, tbl[i].e_lang);
    end

    // F0 abandoned after T idle cycles: the following 1C is a make.
    step(1'b1, 8'hF0, 1'b0);
    repeat (T) step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h1C, 1'b0);
    chk_all("timeout", 1'b1, 1'b0, 10'h01C, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0);

    // Byte coinciding with the timeout is still a break code.
    step(1'b1, 8'hF0, 1'b0);
    repeat (T - 1) step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h1D, 1'b0);
    chk_all("tmo_edge", 1'b0, 1'b0, 10'h01C, 1'b0, 1'b0);
    step(1'b1, 8'h1D, 1'b0);
    chk_all("tmo_after", 1'b1, 1'b0, 10'h01D, 1'b0, 1'b0);

    // Reset during an E0 F0 sequence, coinciding with the final byte.
    step(1'b1, 8'h58, 1'b0);
    step(1'b1, 8'h0E, 1'b0);
    step(1'b1, 8'hE0, 1'b0);
    step(1'b1, 8'hF0, 1'b0);
    step(1'b1, 8'h75, 1'b1);
    chk_all("rst_mid", 1'b0, 1'b0, 10'h000, 1'b0, 1'b0);
    step(1'b1, 8'h1C, 1'b0);
    chk_all("rst_next", 1'b1, 1'b0, 10'h01C, 1'b0, 1'b0);

    // Reset in BRK: a following 12 is a shift press, not a release.
    step(1'b1, 8'hF0, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h12, 1'b0);
    step(1'b1, 8'h1C, 1'b0);
    chk_all("rst_brk", 1'b1, 1'b0, 10'h11C, 1'b0, 1'b0);
    step(1'b1, 8'hF0, 1'b0);
    step(1'b1, 8'h12, 1'b0);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      logic       t;
      logic       r;
      logic [7:0] d;
      t = ($urandom_range(0, 2) != 0);
      r = ($urandom_range(0, 249) == 0);
      d = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                      : pool[$urandom_range(0, 11)];
      if ($urandom_range(0, 59) == 0) begin
        int gap;
        gap = $urandom_range(T - 2, T + 2);
        for (int g = 0; g < gap; g++) begin
          step(1'b0, 8'h00, 1'b0);
          chk_all("rand_gap", m_at, m_ct, m_addr, m_caps, m_lang);
        end
      end
      step(t, d, r);
      chk_all("rand", m_at, m_ct, m_addr, m_caps, m_lang);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/kb_event_decoder.md
KB_EVENT_DECODER -- requirements
Module: kb_event_decoder

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 2000000, is the idle cycles after which a partial prefix sequence is abandoned (20 ms at 100 MHz).
REQ-002 clk  input  1  single system clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 rx_done_tick  input  1  one-cycle strobe: rx_data holds a new PS/2 byte.
REQ-005 rx_data  input  8  received PS/2 byte, valid only with rx_done_tick.
REQ-006 rom_addr  output  10  registered scancode ROM address {lang, upper, scancode[7:0]}.
REQ-007 addr_tick  output  1  one-cycle pulse, same cycle rom_addr takes a new key value.
REQ-008 char_tick  output  1  addr_tick delayed one cycle; ROM data is valid while high.
REQ-009 caps_on  output  1  caps-lock toggle state.
REQ-010 lang  output  1  layout select: 0 = English, 1 = Thai.

Function
REQ-011 The FSM SHALL have states IDLE, BRK (after F0), EXT (after E0) and EXT_BRK (after E0 F0); bytes are consumed only on rx_done_tick.
REQ-012 IDLE: F0 -> BRK; E0 -> EXT; AA/FA/FE/EE ignored; any other byte is a make code (REQ-015), stay IDLE.
REQ-013 BRK: F0 stays BRK; 12 clears shift_l, 59 clears shift_r; any non-F0 byte -> IDLE, no event.
REQ-014 EXT: E0 stays EXT; F0 -> EXT_BRK; other -> IDLE, no event. EXT_BRK: any byte -> IDLE, no event, shift state untouched.
REQ-015 Make code handling: 12 sets shift_l; 59 sets shift_r; 58 toggles caps_on; 0E toggles lang; none of these emits an event; every other code emits one event.
REQ-016 Event: in the cycle after the byte, rom_addr = {lang, (shift_l|shift_r) XOR caps_on, code} and addr_tick = 1, using modifier state before that byte.
REQ-017 char_tick SHALL pulse exactly one cycle after each addr_tick; rom_addr holds its value until the next event.
REQ-018 Repeated make codes (typematic) SHALL each emit an event; break codes never emit.
REQ-019 A cycle counter SHALL clear on every rx_done_tick and count in non-IDLE states; at TIMEOUT_CYCLES-1 the FSM returns to IDLE and the counter clears.
REQ-020 If rx_done_tick and the timeout coincide, the byte SHALL be processed in the current state; the timeout is ignored that cycle.
REQ-021 In IDLE the counter SHALL hold at 0; its width SHALL be clog2(TIMEOUT_CYCLES).
REQ-022 Back-to-back rx_done_tick on consecutive cycles SHALL each be processed; event throughput is one per cycle.

Reset
REQ-023 On reset: state IDLE, counter 0, shift_l = shift_r = 0, caps_on 0, lang 0, rom_addr 10'h000, addr_tick 0, char_tick 0.
REQ-024 Reset SHALL take priority over a concurrent rx_done_tick; that byte is discarded.
REQ-025 Reset mid-sequence (BRK/EXT/EXT_BRK) SHALL return to IDLE; the next byte is treated as a make code.

Verification
REQ-026 Byte 1C -> next cycle rom_addr 0x01C with addr_tick; char_tick the cycle after; no further pulses.
REQ-027 12, 1C, F0 12, 1C -> events 0x11C then 0x01C; F0 12 emits nothing.
REQ-028 58, 1C, 12, 1C -> caps_on 1, events 0x11C then 0x01C (shift XOR caps).
REQ-029 0E, 1C, 0E, 1C -> lang 1 then 0; events 0x21C then 0x01C; 0E emits nothing.
REQ-030 F0, TIMEOUT_CYCLES idle cycles, 1C -> event 0x01C; F0, 1C before the timeout -> no event.
REQ-031 E0 F0 75, then reset asserted one cycle after F0 -> all outputs at reset values; a following 1C -> 0x01C event.
